dcache_blocking_ctrl: RTL

//  Blocking, direct-mapped, write-through data cache that serves the MEM stage.
//  It is the responder side of the pipeline stall protocol.
//  - It raises mem_block_flag_o when an access cannot complete in the same cycle.
//  - It pulses dcache_ready_o when that access finishes.
//  - It obeys ctrl_signal_dcache_i (CTRL_STATE_* codes from `defines.v).

---
 rtl/dcache_blocking_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_blocking_ctrl.sv
// Blocking, direct-mapped, write-through (no write-allocate) data cache for the MEM stage.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_blocking_ctrl #(
    parameter int          ADDR_W           = 64,
    parameter int          DATA_W           = 64,
    parameter int          SETS             = 16,
    parameter int          LINE_WORDS       = 4,
    parameter logic [1:0]  CTRL_STATE_BLOCK = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ctrl_signal_dcache_i,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_block_flag_o,
    output logic              dcache_ready_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WA_W   = ADDR_W - 3;
    localparam int TAG_W  = WA_W - OFF_W - IDX_W;
    localparam int CNT_W  = OFF_W + 1;
    localparam int MEM_AW = IDX_W + OFF_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REFILL_REQ,
        REFILL_DATA,
        WR_REQ,
        DONE
    } state_t;

    state_t            state_reg;
    logic [WA_W-1:0]   addr_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              ready_reg;
    logic              bus_req_reg;
    logic              bus_we_reg;
    logic [ADDR_W-1:0] bus_addr_reg;
    logic [DATA_W-1:0] bus_wdata_reg;

    logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic              valid_reg [SETS];

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  lat_off;
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;

    logic              blocked;
    logic              accept;
    logic              req_hit;
    logic              load_hit;
    logic [DATA_W-1:0] hit_word;
    logic              beat_fire;
    logic              last_beat;
    logic              refill_done;
    logic              valid_clr;
    logic              wr_hit;
    logic [DATA_W-1:0] refill_word;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Byte-offset bits never select anything in a word-addressed cache.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[2:0];

    assign req_off = req_addr_i[3 +: OFF_W];
    assign req_idx = req_addr_i[3+OFF_W +: IDX_W];
    assign req_tag = req_addr_i[ADDR_W-1 -: TAG_W];
    assign lat_off = addr_reg[0 +: OFF_W];
    assign lat_idx = addr_reg[OFF_W +: IDX_W];
    assign lat_tag = addr_reg[WA_W-1 -: TAG_W];

    assign blocked  = (ctrl_signal_dcache_i == CTRL_STATE_BLOCK);
    assign accept   = (state_reg == IDLE) && req_valid_i && !blocked;
    assign req_hit  = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
    assign load_hit = accept && !req_we_i && req_hit;
    assign hit_word = data_mem[{req_idx, req_off}];

    // Refill beats are captured even while the pipeline holds Block.
    assign beat_fire   = (state_reg == REFILL_DATA) && bus_rvalid_i && (beat_cnt_reg < CNT_FULL);
    assign last_beat   = beat_fire && (beat_cnt_reg == CNT_LAST);
    assign refill_done = (state_reg == REFILL_DATA) && (last_beat || (beat_cnt_reg == CNT_FULL));
    assign valid_clr   = (state_reg == REFILL_REQ) && bus_ack_i && !blocked;
    assign wr_hit      = (state_reg == WR_REQ) && bus_ack_i && !blocked &&
                         valid_reg[lat_idx] && (tag_mem[lat_idx] == lat_tag);

    // The final beat has not reached the array yet when the line completes.
    assign refill_word = (lat_off == OFF_LAST) ? bus_rdata_i : data_mem[{lat_idx, lat_off}];

    assign mem_block_flag_o = accept && !load_hit;
    assign rdata_o          = load_hit ? hit_word : rdata_reg;
    assign dcache_ready_o   = ready_reg;
    assign bus_req_o        = bus_req_reg;
    assign bus_we_o         = bus_we_reg;
    assign bus_addr_o       = bus_addr_reg;
    assign bus_wdata_o      = bus_wdata_reg;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (beat_fire) begin
            mem_we    = 1'b1;
            mem_waddr = {lat_idx, beat_cnt_reg[OFF_W-1:0]};
            mem_wdata = bus_rdata_i;
        end else if (wr_hit) begin
            mem_we    = 1'b1;
            mem_waddr = {lat_idx, lat_off};
            mem_wdata = bus_wdata_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem[mem_waddr] <= mem_wdata;
        end
        if (last_beat) begin
            tag_mem[lat_idx] <= lat_tag;
        end
    end

    // The victim line is invalidated when its refill starts so a partial line is never valid.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (valid_clr && (lat_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end else if (last_beat && (lat_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            beat_cnt_reg  <= '0;
            rdata_reg     <= '0;
            ready_reg     <= 1'b0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_hit) begin
                        rdata_reg <= hit_word;
                    end else if (accept) begin
                        addr_reg    <= req_addr_i[ADDR_W-1:3];
                        bus_req_reg <= 1'b1;
                        bus_we_reg  <= req_we_i;
                        if (req_we_i) begin
                            bus_addr_reg  <= {req_addr_i[ADDR_W-1:3], 3'b000};
                            bus_wdata_reg <= req_wdata_i;
                            state_reg     <= WR_REQ;
                        end else begin
                            bus_addr_reg <= {req_addr_i[ADDR_W-1:3+OFF_W], {(OFF_W+3){1'b0}}};
                            state_reg    <= REFILL_REQ;
                        end
                    end
                end
                REFILL_REQ: begin
                    if (!blocked && bus_ack_i) begin
                        bus_req_reg  <= 1'b0;
                        beat_cnt_reg <= '0;
                        state_reg    <= REFILL_DATA;
                    end
                end
                REFILL_DATA: begin
                    if (beat_fire) begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                    end
                    if (last_beat) begin
                        rdata_reg <= refill_word;
                    end
                    if (!blocked && refill_done) begin
                        ready_reg <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                WR_REQ: begin
                    if (!blocked && bus_ack_i) begin
                        bus_req_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    if (!blocked) begin
                        ready_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    ready_reg   <= 1'b0;
                    bus_req_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    // Only loads accepted in IDLE are counted; stores always go to the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (accept && !req_we_i) begin
            if (req_hit) begin
                if (hit_cnt_reg != 32'hFFFF_FFFF) begin
                    hit_cnt_reg <= hit_cnt_reg + 32'd1;
                end
            end else if (miss_cnt_reg != 32'hFFFF_FFFF) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;
`endif

endmodule
